// File: rtl/seg_scan_driver_if.sv
// Load-side bus of the seven-segment scan driver: value/format/mask capture
// strobe toward the driver, busy/done status back to the requester.
interface seg_scan_driver_if;
  logic        load;
  logic [15:0] value;
  logic        dec_mode;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        busy;
  logic        done;

  modport master (
    output load, value, dec_mode, dp_mask, blank_mask,
    input  busy, done
  );

  modport slave (
    input  load, value, dec_mode, dp_mask, blank_mask,
    output busy, done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment driver: latches a 16-bit value as hex or
// BCD (double-dabble), then time-multiplexes digits with blanking, dp and blink.
module seg_scan_driver #(
  parameter logic [31:0] SCAN_DIV  = 32'h20000,
  parameter logic [31:0] BLINK_DIV = 32'd25000000
) (
  input  logic                clk,
  input  logic                reset_n,
  seg_scan_driver_if.slave    bus,
  input  logic                blink,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output logic                dp
);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic        dash_q, dash_d;
  logic [3:0]  dp_mask_q, dp_mask_d;
  logic [3:0]  blank_mask_q, blank_mask_d;
  logic [27:0] disp_code_q, disp_code_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [3:0]  disp_blank_q, disp_blank_d;
  logic [31:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        phase_on_q, phase_on_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic [15:0] adj;
  logic [3:0]  nib;

  function automatic logic [6:0] hex_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Load FSM; bcd_q doubles as the hex digit store so COMMIT has one decode path.
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    dash_d       = dash_q;
    dp_mask_d    = dp_mask_q;
    blank_mask_d = blank_mask_q;
    disp_code_d  = disp_code_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    adj          = '0;
    nib          = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          dp_mask_d    = bus.dp_mask;
          blank_mask_d = bus.blank_mask;
          dash_d       = 1'b0;
          if (!bus.dec_mode) begin
            bcd_d   = bus.value;
            state_d = COMMIT;
          end else if (bus.value > 16'd9999) begin
            dash_d  = 1'b1;
            state_d = COMMIT;
          end else begin
            bin_d   = bus.value[13:0];
            bcd_d   = '0;
            iter_d  = '0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        for (int i = 0; i < 4; i++) begin
          nib = bcd_q[4*i +: 4];
          adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) state_d = COMMIT;
      end
      COMMIT: begin
        for (int i = 0; i < 4; i++)
          disp_code_d[7*i +: 7] = dash_q ? 7'h3F : hex_code(bcd_q[4*i +: 4]);
        disp_dp_d    = dp_mask_q;
        disp_blank_d = blank_mask_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan/blink timing and the registered pin drive, fed only by the display register.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 32'd1;
    digit_d     = digit_q;
    blink_cnt_d = blink_cnt_q + 32'd1;
    phase_on_d  = phase_on_q;
    seg_d       = 7'h7F;
    an_d        = 4'b1111;
    dp_d        = 1'b1;
    if (scan_cnt_q == SCAN_DIV - 32'd1) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end
    if (blink_cnt_q == BLINK_DIV - 32'd1) begin
      blink_cnt_d = '0;
      phase_on_d  = ~phase_on_q;
    end
    if (!(blink && !phase_on_q) && !disp_blank_q[digit_q]) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = disp_code_q[7*digit_q +: 7];
      dp_d  = ~disp_dp_q[digit_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      dash_q       <= 1'b0;
      dp_mask_q    <= '0;
      blank_mask_q <= '0;
      disp_code_q  <= {4{7'h7F}};
      disp_dp_q    <= '0;
      disp_blank_q <= 4'b1111;
      scan_cnt_q   <= '0;
      digit_q      <= '0;
      blink_cnt_q  <= '0;
      phase_on_q   <= 1'b1;
      seg_q        <= 7'h7F;
      an_q         <= 4'b1111;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      dash_q       <= dash_d;
      dp_mask_q    <= dp_mask_d;
      blank_mask_q <= blank_mask_d;
      disp_code_q  <= disp_code_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      scan_cnt_q   <= scan_cnt_d;
      digit_q      <= digit_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_on_q   <= phase_on_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == COMMIT);
  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = dp_q;

endmodule
